// File: rtl/pwm_duty_ramp_if.sv
// Target-write port for pwm_duty_ramp. The writer (master) holds its request
// and data stable until the ramp block (slave) accepts them.
interface pwm_duty_ramp_if #(
  parameter int BIT_LENGTH = 8
);
  logic                  WrValid;
  logic                  WrReady;
  logic [3:0]            WrChan;
  logic [BIT_LENGTH-1:0] WrDuty;
  logic                  WrImmediate;

  modport master (
    output WrValid,
    output WrChan,
    output WrDuty,
    output WrImmediate,
    input  WrReady
  );

  modport slave (
    input  WrValid,
    input  WrChan,
    input  WrDuty,
    input  WrImmediate,
    output WrReady
  );
endinterface

// File: rtl/pwm_duty_ramp.sv
// 16-channel duty ramp sequencer feeding the PWM comparator compare bus.
// Optional PWM_RAMP_SHADOW_EN adds a PeriodSync-loaded shadow bank in front of Cmps.
module pwm_duty_ramp #(
  parameter int BIT_LENGTH = 8,
  parameter int STEP       = 1,
  parameter int TICK_DIV   = 256
) (
  input  logic                     CLK,
  input  logic                     RST,
`ifdef PWM_RAMP_SHADOW_EN
  input  logic                     PeriodSync,
`endif
  pwm_duty_ramp_if.slave           wr,
  output logic [BIT_LENGTH*16-1:0] Cmps,
  output logic                     Busy
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [BIT_LENGTH:0] STEP_EXT = (BIT_LENGTH + 1)'(STEP);

  generate
    if (TICK_DIV < 17) begin : g_bad_tick_div
      $error("pwm_duty_ramp: TICK_DIV must be at least 17");
    end
    if ((STEP < 1) || (STEP > (2 ** BIT_LENGTH) - 1)) begin : g_bad_step
      $error("pwm_duty_ramp: STEP must be in 1..2^BIT_LENGTH-1");
    end
  endgenerate

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [PW-1:0]         prescaler;
  logic                  tick;
  logic [3:0]            scan_idx;
  logic [BIT_LENGTH-1:0] cur [16];
  logic [BIT_LENGTH-1:0] tgt [16];
  logic                  wr_fire;
  logic [BIT_LENGTH-1:0] cur_sel;
  logic [BIT_LENGTH-1:0] tgt_sel;
  logic [BIT_LENGTH:0]   up_sum;
  logic [BIT_LENGTH:0]   dn_diff;
  logic [BIT_LENGTH-1:0] step_val;
  logic                  any_diff;

  assign tick       = (prescaler == TICK_LAST);
  assign wr.WrReady = (state == IDLE) && !tick;
  assign wr_fire    = wr.WrValid && wr.WrReady;

  always_ff @(posedge CLK) begin
    if (RST) begin
      prescaler <= '0;
    end else if (tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + PW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (tick) state_next = SCAN;
      SCAN:    if (scan_idx == 4'd15) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      scan_idx <= 4'd0;
    end else if ((state == IDLE) && tick) begin
      scan_idx <= 4'd0;
    end else if (state == SCAN) begin
      scan_idx <= scan_idx + 4'd1;
    end
  end

  // One shared saturating step: the extra top bit catches underflow, and both
  // directions clamp to the target so a large STEP can never overshoot.
  always_comb begin
    cur_sel  = cur[scan_idx];
    tgt_sel  = tgt[scan_idx];
    up_sum   = {1'b0, cur_sel} + STEP_EXT;
    dn_diff  = {1'b0, cur_sel} - STEP_EXT;
    step_val = cur_sel;
    if (cur_sel < tgt_sel) begin
      step_val = (up_sum > {1'b0, tgt_sel}) ? tgt_sel : up_sum[BIT_LENGTH-1:0];
    end else if (cur_sel > tgt_sel) begin
      step_val = (dn_diff[BIT_LENGTH] || (dn_diff < {1'b0, tgt_sel}))
                 ? tgt_sel : dn_diff[BIT_LENGTH-1:0];
    end
  end

  // Writes only land in IDLE, so they never collide with the scan update.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int n = 0; n < 16; n++) begin
        cur[n] <= '0;
        tgt[n] <= '0;
      end
    end else begin
      if (wr_fire) begin
        tgt[wr.WrChan] <= wr.WrDuty;
        if (wr.WrImmediate) begin
          cur[wr.WrChan] <= wr.WrDuty;
        end
      end
      if (state == SCAN) begin
        cur[scan_idx] <= step_val;
      end
    end
  end

  always_comb begin
    any_diff = 1'b0;
    for (int n = 0; n < 16; n++) begin
      any_diff = any_diff | (cur[n] != tgt[n]);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      Busy <= 1'b0;
    end else begin
      Busy <= any_diff;
    end
  end

`ifdef PWM_RAMP_SHADOW_EN
  logic [BIT_LENGTH-1:0] shadow [16];

  // Snapshot all live values at the comparator's period wrap.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int n = 0; n < 16; n++) begin
        shadow[n] <= '0;
      end
    end else if (PeriodSync) begin
      for (int n = 0; n < 16; n++) begin
        shadow[n] <= cur[n];
      end
    end
  end

  for (genvar n = 0; n < 16; n++) begin : g_cmps
    assign Cmps[BIT_LENGTH*n +: BIT_LENGTH] = shadow[n];
  end
`else
  for (genvar n = 0; n < 16; n++) begin : g_cmps
    assign Cmps[BIT_LENGTH*n +: BIT_LENGTH] = cur[n];
  end
`endif

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp: two instances (STEP 4 and STEP 8) share
// clock, reset and write traffic; cycle numbers count edges since reset release.
module tb_pwm_duty_ramp;

  localparam int BL   = 8;
  localparam int TDIV = 20;

  logic            CLK;
  logic            RST;
  logic [BL*16-1:0] cmpsA;
  logic [BL*16-1:0] cmpsB;
  logic            busyA;
  logic            busyB;
`ifdef PWM_RAMP_SHADOW_EN
  logic            PeriodSync;
`endif

  int nCompared   = 0;
  int nMismatched = 0;
  int cyc         = 0;

  pwm_duty_ramp_if #(.BIT_LENGTH(BL)) ifA ();
  pwm_duty_ramp_if #(.BIT_LENGTH(BL)) ifB ();

  pwm_duty_ramp #(.BIT_LENGTH(BL), .STEP(4), .TICK_DIV(TDIV)) dutA (
    .CLK        (CLK),
    .RST        (RST),
`ifdef PWM_RAMP_SHADOW_EN
    .PeriodSync (PeriodSync),
`endif
    .wr         (ifA.slave),
    .Cmps       (cmpsA),
    .Busy       (busyA)
  );

  pwm_duty_ramp #(.BIT_LENGTH(BL), .STEP(8), .TICK_DIV(TDIV)) dutB (
    .CLK        (CLK),
    .RST        (RST),
`ifdef PWM_RAMP_SHADOW_EN
    .PeriodSync (PeriodSync),
`endif
    .wr         (ifB.slave),
    .Cmps       (cmpsB),
    .Busy       (busyB)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (RST) cyc = 0;
    else     cyc = cyc + 1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    int cyc;
    bit doWr;
    int wrChan;
    int wrDuty;
    bit wrImm;
    int unit;
    int chan;
    int expCmp;
    int expBusy;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input int act, input int exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int getCmp(input logic [BL*16-1:0] bus, input int ch);
    return int'(bus[ch*BL +: BL]);
  endfunction

  task automatic gotoCycle(input int c);
    while (cyc < c) @(negedge CLK);
  endtask

  task automatic writeBoth(input int ch, input int duty, input bit imm);
    checkOutput($sformatf("wrready_A_c%0d", cyc), int'(ifA.WrReady), 1);
    checkOutput($sformatf("wrready_B_c%0d", cyc), int'(ifB.WrReady), 1);
    ifA.WrValid = 1'b1; ifA.WrChan = 4'(ch); ifA.WrDuty = BL'(duty); ifA.WrImmediate = imm;
    ifB.WrValid = 1'b1; ifB.WrChan = 4'(ch); ifB.WrDuty = BL'(duty); ifB.WrImmediate = imm;
    @(negedge CLK);
    ifA.WrValid = 1'b0;
    ifB.WrValid = 1'b0;
  endtask

  task automatic doReset();
    RST = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    logic [BL*16-1:0] bus;
    logic             b;
    gotoCycle(v.cyc);
    bus = (v.unit == 0) ? cmpsA : cmpsB;
    b   = (v.unit == 0) ? busyA : busyB;
    if (v.expCmp >= 0)
      checkOutput($sformatf("vec%0d_u%0d_ch%0d_cmp", idx, v.unit, v.chan), getCmp(bus, v.chan), v.expCmp);
    if (v.expBusy >= 0)
      checkOutput($sformatf("vec%0d_u%0d_busy", idx, v.unit), int'(b), v.expBusy);
    if (v.doWr) writeBoth(v.wrChan, v.wrDuty, v.wrImm);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_cmpsA_zero"}, int'(|cmpsA), 0);
    checkOutput({tag, "_cmpsB_zero"}, int'(|cmpsB), 0);
    checkOutput({tag, "_busyA"}, int'(busyA), 0);
    checkOutput({tag, "_busyB"}, int'(busyB), 0);
    checkOutput({tag, "_wrreadyA"}, int'(ifA.WrReady), 1);
  endtask

  initial begin
    int split;
    int lowCount;
    int acceptCyc;

    ifA.WrValid = 1'b0; ifA.WrChan = 4'd0; ifA.WrDuty = '0; ifA.WrImmediate = 1'b0;
    ifB.WrValid = 1'b0; ifB.WrChan = 4'd0; ifB.WrDuty = '0; ifB.WrImmediate = 1'b0;
`ifdef PWM_RAMP_SHADOW_EN
    PeriodSync = 1'b0;
`endif

    // cyc, doWr, wrChan, wrDuty, wrImm, unit(0=STEP4,1=STEP8), chan, expCmp, expBusy
    vecs.push_back('{1,    1, 3, 10,  0, 0, 3, 0,   0});
    vecs.push_back('{1,    0, 0, 0,   0, 1, 3, 0,   0});
    vecs.push_back('{2,    0, 0, 0,   0, 0, 3, 0,   0});
    vecs.push_back('{3,    0, 0, 0,   0, 0, 3, 0,   1});
    vecs.push_back('{3,    0, 0, 0,   0, 1, 3, 0,   1});
    vecs.push_back('{23,   0, 0, 0,   0, 0, 3, 0,   1});
    vecs.push_back('{24,   0, 0, 0,   0, 0, 3, 4,   1});
    vecs.push_back('{24,   0, 0, 0,   0, 1, 3, 8,   1});
    vecs.push_back('{43,   0, 0, 0,   0, 0, 3, 4,  -1});
    vecs.push_back('{44,   0, 0, 0,   0, 0, 3, 8,   1});
    vecs.push_back('{44,   0, 0, 0,   0, 1, 3, 10,  1});
    vecs.push_back('{45,   0, 0, 0,   0, 1, 3, 10,  0});
    vecs.push_back('{64,   0, 0, 0,   0, 0, 3, 10,  1});
    vecs.push_back('{65,   0, 0, 0,   0, 0, 3, 10,  0});
    vecs.push_back('{76,   1, 0, 200, 1, 0, 0, 0,   0});
    vecs.push_back('{77,   0, 0, 0,   0, 0, 0, 200, 0});
    vecs.push_back('{77,   0, 0, 0,   0, 1, 0, 200, 0});
    vecs.push_back('{78,   1, 0, 2,   0, 1, 0, 200, 0});
    vecs.push_back('{79,   0, 0, 0,   0, 1, 0, 200, 0});
    vecs.push_back('{80,   0, 0, 0,   0, 1, 0, 200, 1});
    vecs.push_back('{81,   0, 0, 0,   0, 1, 0, 192, 1});
    vecs.push_back('{81,   0, 0, 0,   0, 0, 0, 196, 1});
    vecs.push_back('{101,  0, 0, 0,   0, 1, 0, 184, 1});
    vecs.push_back('{541,  0, 0, 0,   0, 1, 0, 8,   1});
    vecs.push_back('{561,  0, 0, 0,   0, 1, 0, 2,   1});
    vecs.push_back('{562,  0, 0, 0,   0, 1, 0, 2,   0});
    vecs.push_back('{580,  0, 0, 0,   0, 0, 0, 100, 1});
    split = vecs.size();
    vecs.push_back('{636,  1, 9, 30,  1, 1, 9, 0,   0});
    vecs.push_back('{637,  1, 9, 40,  1, 1, 9, 30,  0});
    vecs.push_back('{638,  0, 0, 0,   0, 1, 9, 40,  0});
    vecs.push_back('{1041, 0, 0, 0,   0, 0, 0, 4,   1});
    vecs.push_back('{1061, 0, 0, 0,   0, 0, 0, 2,   1});
    vecs.push_back('{1062, 0, 0, 0,   0, 0, 0, 2,   0});
    vecs.push_back('{1062, 0, 0, 0,   0, 0, 3, 10, -1});

    doReset();
    checkResetState("reset");

`ifdef PWM_RAMP_SHADOW_EN
    gotoCycle(2);
    writeBoth(5, 77, 1'b1);
    gotoCycle(4);
    checkOutput("shadow_ch5_before_A_c4", getCmp(cmpsA, 5), 0);
    gotoCycle(33);
    checkOutput("shadow_ch5_before_A_c33", getCmp(cmpsA, 5), 0);
    checkOutput("shadow_ch5_before_B_c33", getCmp(cmpsB, 5), 0);
    PeriodSync = 1'b1;
    @(negedge CLK);
    PeriodSync = 1'b0;
    checkOutput("shadow_ch5_after_A", getCmp(cmpsA, 5), 77);
    checkOutput("shadow_ch5_after_B", getCmp(cmpsB, 5), 77);
`else
    for (int i = 0; i < split; i++) applyStimulus(vecs[i], i);

    // WrValid raised on the tick cycle must wait out the whole scan.
    gotoCycle(599);
    ifA.WrValid = 1'b1; ifA.WrChan = 4'd7; ifA.WrDuty = BL'(50); ifA.WrImmediate = 1'b1;
    ifB.WrValid = 1'b1; ifB.WrChan = 4'd7; ifB.WrDuty = BL'(50); ifB.WrImmediate = 1'b1;
    lowCount  = 0;
    acceptCyc = -1;
    for (int i = 0; i < 40; i++) begin
      if (ifA.WrReady) begin
        acceptCyc = cyc;
        checkOutput("hold_wrreadyB_at_accept", int'(ifB.WrReady), 1);
        @(negedge CLK);
        break;
      end
      lowCount++;
      @(negedge CLK);
    end
    ifA.WrValid = 1'b0;
    ifB.WrValid = 1'b0;
    checkOutput("hold_wrready_low_cycles", lowCount, 17);
    checkOutput("hold_accept_cycle", acceptCyc, 616);
    gotoCycle(617);
    checkOutput("hold_ch7_A", getCmp(cmpsA, 7), 50);
    checkOutput("hold_ch7_B", getCmp(cmpsB, 7), 50);
    gotoCycle(618);
    checkOutput("hold_busyB", int'(busyB), 0);

    for (int i = split; i < vecs.size(); i++) applyStimulus(vecs[i], i);

    // Reset in the middle of a scan wipes both the done and pending steps.
    gotoCycle(1096);
    writeBoth(2, 100, 1'b0);
    gotoCycle(1102);
    checkOutput("midscan_ch2_A_c1102", getCmp(cmpsA, 2), 0);
    gotoCycle(1103);
    checkOutput("midscan_ch2_A_c1103", getCmp(cmpsA, 2), 4);
    checkOutput("midscan_ch2_B_c1103", getCmp(cmpsB, 2), 8);
    gotoCycle(1105);
    doReset();
    checkResetState("midscan_reset");
    gotoCycle(1);
    writeBoth(1, 12, 1'b0);
    gotoCycle(21);
    checkOutput("post_reset_ch1_A_c21", getCmp(cmpsA, 1), 0);
    gotoCycle(22);
    checkOutput("post_reset_ch1_A_c22", getCmp(cmpsA, 1), 4);
    checkOutput("post_reset_ch1_B_c22", getCmp(cmpsB, 1), 8);
    gotoCycle(23);
    checkOutput("post_reset_ch2_A", getCmp(cmpsA, 2), 0);
    checkOutput("post_reset_ch2_B", getCmp(cmpsB, 2), 0);
    checkOutput("post_reset_busyA", int'(busyA), 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
